// File: rtl/ahb_addr_decoder_if.sv
// AHB-Lite decoder bus bundle: master-side address/transfer, per-slave select and responses.
// Latency: none (signal bundle only).
// Backpressure: hready carries the muxed wait state back to the master and every slave.
//
// Ports (signals):
//   haddr, htrans          master address phase
//   hsel                   one-hot address-phase slave select
//   hrdata_s, hreadyout_s, hresp_s   concatenated slave responses, slice i = slave i
//   hrdata, hready, hresp  muxed response to the master
// Modports:
//   master - the surrounding fabric (bus master plus slave response sources)
//   slave  - the decoder itself
interface ahb_addr_decoder_if #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [ADDR_W-1:0]         haddr;
  logic [1:0]                htrans;
  logic [NUM_SLV-1:0]        hsel;
  logic [NUM_SLV*DATA_W-1:0] hrdata_s;
  logic [NUM_SLV-1:0]        hreadyout_s;
  logic [NUM_SLV-1:0]        hresp_s;
  logic [DATA_W-1:0]         hrdata;
  logic                      hready;
  logic                      hresp;

  modport master (
    output haddr, htrans, hrdata_s, hreadyout_s, hresp_s,
    input  hsel, hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hrdata_s, hreadyout_s, hresp_s,
    output hsel, hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_addr_decoder.sv
// AHB-Lite address decoder + response mux with built-in default (ERROR) slave.
// Latency: hsel 0 cycles; response routed one cycle after the accepted address phase.
// Backpressure: hready low freezes the data-phase owner; unmapped transfers get a 2-cycle ERROR.
//
// Ports:
//   hclk     bus clock (rising edge)
//   hreset   asynchronous active-high reset
//   bus      ahb_addr_decoder_if.slave (haddr/htrans in, hsel out, slave responses in, muxed response out)
//   err_cnt  saturating count of ERROR responses issued by the default slave
// Optional feature: define AHB_DEC_ERR_CNT_EN to implement err_cnt; otherwise it is tied to 0.
module ahb_addr_decoder #(
  parameter int NUM_SLV   = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {NUM_SLV{32'hF000_0000}},
  parameter int ERR_CNT_W = 8
) (
  input  logic                 hclk,
  input  logic                 hreset,
  ahb_addr_decoder_if.slave    bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Owner index NUM_SLV denotes the internal default slave.
  localparam int IDX_W = $clog2(NUM_SLV + 1);
  localparam logic [IDX_W-1:0] DSEL_DEF = IDX_W'(NUM_SLV);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  logic [NUM_SLV-1:0] hsel_w;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               unmapped_req;

  logic [DATA_W-1:0]  hrdata_w;
  logic               hready_w;
  logic               hresp_w;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   dsel_q, dsel_d;
  logic               def_hready_q, def_hready_d;
  logic               def_hresp_q, def_hresp_d;

  // BUSY and NONSEQ/SEQ are told apart by htrans[1] alone.
  logic unused_htrans0;
  assign unused_htrans0 = bus.htrans[0];

  // Address decode: first matching slave from index 0 upward wins, keeping hsel one-hot.
  always_comb begin
    hsel_w  = '0;
    hit     = 1'b0;
    hit_idx = DSEL_DEF;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (!hit && ((bus.haddr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        hit       = 1'b1;
        hsel_w[i] = 1'b1;
        hit_idx   = IDX_W'(i);
      end
    end
  end

  assign unmapped_req = !hit && bus.htrans[1];

  // Response mux: default slave supplies hrdata = 0 and its FSM-driven ready/resp.
  always_comb begin
    hrdata_w = '0;
    hready_w = def_hready_q;
    hresp_w  = def_hresp_q;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dsel_q == IDX_W'(i)) begin
        hrdata_w = bus.hrdata_s[i*DATA_W +: DATA_W];
        hready_w = bus.hreadyout_s[i];
        hresp_w  = bus.hresp_s[i];
      end
    end
  end

  always_comb begin
    dsel_d  = hready_w ? hit_idx : dsel_q;
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (hready_w && unmapped_req) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      // ERR2 always presents hready = 1, so the current address phase is accepted here.
      ST_ERR2: state_d = unmapped_req ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Default-slave outputs are registered alongside the state they belong to.
    def_hready_d = (state_d != ST_ERR1);
    def_hresp_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q      <= ST_IDLE;
      dsel_q       <= DSEL_DEF;
      def_hready_q <= 1'b1;
      def_hresp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dsel_q       <= dsel_d;
      def_hready_q <= def_hready_d;
      def_hresp_q  <= def_hresp_d;
    end
  end

`ifdef AHB_DEC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // ERR1 is only ever entered from IDLE or ERR2, so state_d == ERR1 marks each new error.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_d == ST_ERR1) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign bus.hsel   = hsel_w;
  assign bus.hrdata = hrdata_w;
  assign bus.hready = hready_w;
  assign bus.hresp  = hresp_w;

endmodule
